// File: rtl/pbkdf2_pkg.sv
// Shared types and widths for the PBKDF2-HMAC-SHA512 iteration controller.
`timescale 1ns/1ps
package pbkdf2_pkg;

  localparam int KEY_W     = 1024;
  localparam int SALT_W    = 256;
  localparam int DIGEST_W  = 512;
  localparam int BLK_IDX_W = 32;
  localparam int PAD_W     = DIGEST_W - SALT_W - BLK_IDX_W;

  localparam logic MODE_36B = 1'b0;
  localparam logic MODE_64B = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    ACC,
    FIN
  } pbkdf2_state_t;

endpackage

// File: rtl/pbkdf2_ctrl.sv
// Sequences an external hmac core through c PBKDF2 iterations and XOR-accumulates the result.
// Optional cycle counter output enabled by defining PBKDF2_CTRL_PERF_CNT_EN.
`timescale 1ns/1ps
module pbkdf2_ctrl
  import pbkdf2_pkg::*;
#(
  parameter int ITER_W = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [KEY_W-1:0]     key,
  input  logic [SALT_W-1:0]    salt,
  input  logic [BLK_IDX_W-1:0] blk_idx,
  input  logic [ITER_W-1:0]    iters,
  output logic                 busy,
  output logic                 done,
  output logic [DIGEST_W-1:0]  dk,
  output logic                 hmac_reset,
  output logic                 hmac_mode,
  output logic [KEY_W-1:0]     hmac_key,
  output logic [DIGEST_W-1:0]  hmac_msg,
  input  logic                 hmac_done,
  input  logic [DIGEST_W-1:0]  hmac_oH
`ifdef PBKDF2_CTRL_PERF_CNT_EN
  ,
  output logic [31:0]          cycle_cnt
`endif
);

  pbkdf2_state_t     state, state_nxt;
  logic [ITER_W-1:0] iter_j;
  logic [ITER_W-1:0] c_eff;
  logic [DIGEST_W-1:0] acc_t;
  logic              accept;
  logic              last_iter;

  assign accept    = (state == IDLE) && start;
  assign last_iter = (iter_j == c_eff);
  assign busy      = (state != IDLE);
  assign done      = (state == FIN);

  // NOTE: next-state is defaulted to the current state first so no path leaves it unassigned (no latch).
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = LAUNCH;
      LAUNCH:  state_nxt = WAIT;
      WAIT:    if (hmac_done) state_nxt = ACC;
      ACC:     state_nxt = last_iter ? FIN : LAUNCH;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: the wide datapath registers are reset too, because their reset values are observable outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      iter_j     <= '0;
      c_eff      <= '0;
      acc_t      <= '0;
      dk         <= '0;
      hmac_reset <= 1'b0;
      hmac_mode  <= MODE_36B;
      hmac_key   <= '0;
      hmac_msg   <= '0;
    end else begin
      // Low in IDLE and LAUNCH: the LAUNCH cycle restarts the core and clears any stale done.
      hmac_reset <= (state_nxt == WAIT) || (state_nxt == ACC) || (state_nxt == FIN);

      if (accept) begin
        hmac_key  <= key;
        hmac_msg  <= {salt, blk_idx, {PAD_W{1'b0}}};
        hmac_mode <= MODE_36B;
        iter_j    <= ITER_W'(1);
        c_eff     <= (iters == '0) ? ITER_W'(1) : iters;
        acc_t     <= '0;
      end

      if (state == ACC) begin
        acc_t     <= acc_t ^ hmac_oH;
        hmac_msg  <= hmac_oH;
        hmac_mode <= MODE_64B;
        // j stops at c_eff, so the increment can never wrap even for the all-ones count.
        if (last_iter) begin
          dk <= acc_t ^ hmac_oH;
        end else begin
          iter_j <= iter_j + ITER_W'(1);
        end
      end
    end
  end

`ifdef PBKDF2_CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      cycle_cnt <= '0;
    end else if (accept) begin
      cycle_cnt <= '0;
    end else if (busy && (cycle_cnt != '1)) begin
      cycle_cnt <= cycle_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pbkdf2_ctrl.sv
// Self-checking bench for pbkdf2_ctrl with a fixed-latency behavioural stand-in for the hmac core.
`timescale 1ns/1ps
module tb_pbkdf2_ctrl;
  import pbkdf2_pkg::*;

  localparam int L = 5;

  typedef struct {
    logic [KEY_W-1:0]  key;
    logic [SALT_W-1:0] salt;
    logic [31:0]       blk;
    logic [31:0]       iters;
    int                exp_launch;
    int                exp_lat;
  } vec_t;

  logic                clk = 1'b0;
  logic                reset;
  logic                start;
  logic [KEY_W-1:0]    key;
  logic [SALT_W-1:0]   salt;
  logic [31:0]         blk_idx;
  logic [31:0]         iters;
  logic                busy;
  logic                done;
  logic [DIGEST_W-1:0] dk;
  logic                hmac_reset;
  logic                hmac_mode;
  logic [KEY_W-1:0]    hmac_key;
  logic [DIGEST_W-1:0] hmac_msg;
  logic                hmac_done = 1'b0;
  logic [DIGEST_W-1:0] hmac_oH = '0;
`ifdef PBKDF2_CTRL_PERF_CNT_EN
  logic [31:0]         cycle_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int unsigned hm_cnt = 0;
  int launch_total = 0;
  int done_total = 0;
  logic mode_log [64];

  always #5 clk = ~clk;

  pbkdf2_ctrl #(.ITER_W(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .key        (key),
    .salt       (salt),
    .blk_idx    (blk_idx),
    .iters      (iters),
    .busy       (busy),
    .done       (done),
    .dk         (dk),
    .hmac_reset (hmac_reset),
    .hmac_mode  (hmac_mode),
    .hmac_key   (hmac_key),
    .hmac_msg   (hmac_msg),
    .hmac_done  (hmac_done),
    .hmac_oH    (hmac_oH)
`ifdef PBKDF2_CTRL_PERF_CNT_EN
    ,
    .cycle_cnt  (cycle_cnt)
`endif
  );

  // Stand-in digest: mode-dependent, nonlinear in the message, keyed.
  function automatic logic [DIGEST_W-1:0] hmac_f(input logic [KEY_W-1:0] k,
                                                 input logic [DIGEST_W-1:0] m,
                                                 input logic md);
    logic [DIGEST_W-1:0] mm, r;
    mm = md ? m : {m[511:224], 224'b0};
    r  = {mm[498:0], mm[511:499]} + (k[511:0] ^ {k[959:512], k[1023:960]});
    r  = r ^ (mm >> 5) ^ {64{md ? 8'hC3 : 8'h5A}};
    return r;
  endfunction

  function automatic logic [DIGEST_W-1:0] model_dk(input vec_t v);
    logic [DIGEST_W-1:0] u, t;
    int unsigned c;
    c = (v.iters == 0) ? 1 : v.iters;
    u = hmac_f(v.key, {v.salt, v.blk, 224'b0}, 1'b0);
    t = u;
    for (int unsigned j = 2; j <= c; j++) begin
      u = hmac_f(v.key, u, 1'b1);
      t = t ^ u;
    end
    return t;
  endfunction

  // Core stand-in: done rises in the L-th cycle after hmac_reset goes high; cleared while low.
  always @(posedge clk) begin
    if (!hmac_reset) begin
      hm_cnt    <= 0;
      hmac_done <= 1'b0;
    end else begin
      if (!hmac_done && (hm_cnt + 1 >= L - 1)) begin
        hmac_done <= 1'b1;
        hmac_oH   <= hmac_f(hmac_key, hmac_msg, hmac_mode);
      end
      hm_cnt <= hm_cnt + 1;
    end
  end

  always @(negedge clk) begin
    if (busy && !hmac_reset) begin
      mode_log[launch_total % 64] <= hmac_mode;
      launch_total <= launch_total + 1;
    end
    if (done) done_total <= done_total + 1;
  end

  task automatic check(input string name, input logic [DIGEST_W-1:0] act, input logic [DIGEST_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic apply_inputs(input vec_t v);
    key     = v.key;
    salt    = v.salt;
    blk_idx = v.blk;
    iters   = v.iters;
  endtask

  // Starts a job from IDLE, returns edges from start raised to done seen; ends back in IDLE.
  task automatic run_job(input vec_t v, output int lat);
    apply_inputs(v);
    start = 1'b1;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      start = 1'b0;
    end while (!done && lat < 1000);
    if (!done) check("job_timeout", 1, 0);
    @(posedge clk); #1;
  endtask

  vec_t vecs [4];

  initial begin
    int lat, base_l, base_d, n;
    vec_t va, vb;

    vecs[0] = '{key: {64'h70617373776f7264, 960'b0}, salt: {32{8'h73}}, blk: 32'd1, iters: 32'd1,
                exp_launch: 1, exp_lat: 8};
    vecs[1] = '{key: {64'h70617373776f7264, 960'b0}, salt: {32{8'h73}}, blk: 32'd1, iters: 32'd3,
                exp_launch: 3, exp_lat: 22};
    vecs[2] = '{key: {64'h70617373776f7264, 960'b0}, salt: {32{8'h73}}, blk: 32'd1, iters: 32'd0,
                exp_launch: 1, exp_lat: 8};
    vecs[3] = '{key: {48'h736563726574, 976'b0}, salt: {8{32'hdeadbeef}}, blk: 32'd2, iters: 32'd2,
                exp_launch: 2, exp_lat: 15};

    reset = 1'b0;
    start = 1'b0;
    key = '0; salt = '0; blk_idx = '0; iters = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_dk", dk, 0);
    check("rst_hmac_reset", hmac_reset, 0);
    check("rst_hmac_mode", hmac_mode, 0);
    check("rst_hmac_msg", hmac_msg, 0);
    check("rst_hmac_key", hmac_key, 0);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_hmac_reset", hmac_reset, 0);

    for (int i = 0; i < 4; i++) begin
      base_l = launch_total;
      base_d = done_total;
      run_job(vecs[i], lat);
      check($sformatf("v%0d_dk", i), dk, model_dk(vecs[i]));
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_launches", i), launch_total - base_l, vecs[i].exp_launch);
      check($sformatf("v%0d_dones", i), done_total - base_d, 1);
      check($sformatf("v%0d_idle", i), busy, 0);
      for (int k = 0; k < vecs[i].exp_launch; k++)
        check($sformatf("v%0d_mode%0d", i, k), mode_log[(base_l + k) % 64], (k == 0) ? 0 : 1);
    end

    // Reset pulse during the second WAIT of a 3-iteration job.
    base_l = launch_total;
    base_d = done_total;
    apply_inputs(vecs[1]);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!((launch_total - base_l) >= 2 && hmac_reset && busy) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("midrst_reach_wait2", n < 200, 1);
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    check("midrst_busy", busy, 0);
    check("midrst_dk", dk, 0);
    check("midrst_hmac_reset", hmac_reset, 0);
    repeat (3 * (L + 2) + 5) @(posedge clk);
    #1;
    check("midrst_no_done", done_total - base_d, 0);
    check("midrst_still_idle", busy, 0);
    run_job(vecs[1], lat);
    check("midrst_rerun_dk", dk, model_dk(vecs[1]));

    // start held across a job and two more cycles, inputs changed right after accept.
    va = vecs[3];
    vb = vecs[0];
    base_d = done_total;
    apply_inputs(va);
    start = 1'b1;
    @(posedge clk); #1;
    check("held_accept_busy", busy, 1);
    apply_inputs(vb);
    n = 0;
    while (!done && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("held_done_seen", done, 1);
    check("held_dk_first", dk, model_dk(va));
    @(posedge clk); #1;
    check("held_fin_to_idle", busy, 0);
    @(posedge clk); #1;
    check("held_reaccept", busy, 1);
    start = 1'b0;
    n = 0;
    while (!done && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("held_dk_second", dk, model_dk(vb));
    @(posedge clk); #1;
    check("held_done_count", done_total - base_d, 2);

`ifdef PBKDF2_CTRL_PERF_CNT_EN
    run_job(vecs[3], lat);
    check("perf_cnt", cycle_cnt, 2 * (L + 2) + 1);
    repeat (3) @(posedge clk);
    #1;
    check("perf_cnt_hold", cycle_cnt, 2 * (L + 2) + 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
